pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline registers (ID/EX class).
- Carries one instruction word plus a generic payload bus between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so back-pressure is absorbed without a combinational ready path.
- Separates stall (back-pressure, hold contents) from flush (kill contents, insert bubble). The older hold-only register cannot distinguish these.

Parameters:
- DW, 96, payload width in bits (e.g. addr+op1+op2 concatenated by the instantiating stage).
- INST_W, 32, instruction field width.
- NOP_INST, 32'h00000013, value driven on dn_inst_o for a bubble (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush_i  input  1  kill all held entries this cycle.
- up_valid_i  input  1  upstream offers an entry.
- up_ready_o  output  1  block can accept an entry; registered.
- up_inst_i  input  INST_W  upstream instruction.
- up_data_i  input  DW  upstream payload.
- dn_valid_o  output  1  downstream entry valid.
- dn_ready_i  input  1  downstream accepts.
- dn_inst_o  output  INST_W  downstream instruction.
- dn_data_o  output  DW  downstream payload.

Behaviour:
- Handshake events:
  - up fire = up_valid_i & up_ready_o.
  - dn fire = dn_valid_o & dn_ready_i.
- Storage:
  - main register (drives dn_*).
  - skid register (holds an entry accepted while downstream stalled).
- States: EMPTY (main invalid), BUSY (main valid, skid empty), FULL (both valid).
- Output decode:
  - dn_valid_o = (state != EMPTY).
  - up_ready_o = (state != FULL), registered from the next-state decode, no combinational path from dn_ready_i.
- Reset (rst=1 at an edge):
  - state EMPTY, dn_valid_o=0, up_ready_o=1.
  - dn_inst_o=NOP_INST, dn_data_o=0, skid contents=NOP_INST/0.
- EMPTY:
  - up fire -> BUSY; main <= up.
  - otherwise stay.
- BUSY:
  - up fire & dn fire -> BUSY; main <= up.
  - up fire & !dn fire -> FULL; skid <= up.
  - !up fire & dn fire -> EMPTY; main <= NOP_INST/0.
  - neither -> hold.
- FULL:
  - dn fire -> BUSY; main <= skid; skid <= NOP_INST/0.
  - no up fire possible, since up_ready_o=0.
  - !dn fire -> hold both.
- Priority: rst > flush_i > normal transitions.
- flush_i=1 at an edge:
  - state EMPTY; main and skid <= NOP_INST/0; up_ready_o=1 next cycle.
  - An up fire in the same cycle is discarded. Upstream sees it as accepted; no entry appears downstream.
  - A dn fire in the same cycle still counts as consumed by downstream.
- Latency: 1 cycle from up fire to dn_valid_o.
- Throughput: 1 entry/cycle when dn_ready_i held high.
- Ordering: strictly FIFO; skid entry always precedes any later entry.
- Data stability: while dn_valid_o=1 & dn_ready_i=0, dn_inst_o/dn_data_o are unchanged.
- In EMPTY, dn_inst_o always = NOP_INST and dn_data_o = 0. Downstream may ignore dn_valid_o and treat the output as a bubble.
- Widths are carried verbatim; no arithmetic.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With the macro defined, two extra output ports exist:
  - stall_cnt_o [31:0]: increments each cycle with dn_valid_o=1 & dn_ready_i=0.
  - flush_cnt_o [31:0]: increments each cycle flush_i=1 while state != EMPTY.
  - Both cleared by rst and wrap modulo 2^32.
- Without the macro: the ports and counters are absent, and the core behaviour is identical.

Test Plan:
- Reset then idle: rst high 2 cycles -> dn_valid_o=0, up_ready_o=1, dn_inst_o=32'h00000013, dn_data_o=0.
- Streaming: dn_ready_i=1, send inst 0x00100093, 0x00200113, 0x00300193 back-to-back -> each appears 1 cycle after its fire, consecutive cycles, up_ready_o stays 1.
- Stall fill: dn_ready_i=0, send A=0x11, B=0x22 -> after A, state BUSY. After B, state FULL and up_ready_o=0. A held on dn_*. Release dn_ready_i -> A then B, no loss or duplication, up_ready_o returns to 1 one cycle after the first dn fire.
- Flush in FULL: state FULL with A,B, assert flush_i with up_valid_i=1 carrying C -> next cycle dn_valid_o=0, dn_inst_o=NOP_INST, up_ready_o=1; A, B and C never appear downstream.
- Reset mid-operation: FULL state, rst=1 together with flush_i=1 and dn_ready_i=1 -> outputs equal reset values next cycle; subsequent entry D flows with 1-cycle latency.
- PIPE_STAGE_PERF_EN: 5 stall cycles, then a flush while BUSY -> stall_cnt_o=5, flush_cnt_o=1. A flush while EMPTY leaves flush_cnt_o unchanged.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, separate stall and flush.
// Optional PIPE_STAGE_PERF_EN adds stall/flush event counters on extra output ports.
module pipe_stage_skid #(
    parameter int                 DW       = 96,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [INST_W-1:0] up_inst_i,
    input  logic [DW-1:0]     up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [INST_W-1:0] dn_inst_o,
    output logic [DW-1:0]     dn_data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [INST_W-1:0]   main_inst_r;
    logic [INST_W-1:0]   main_inst_nxt_s;
    logic [DW-1:0]       main_data_r;
    logic [DW-1:0]       main_data_nxt_s;
    logic [INST_W-1:0]   skid_inst_r;
    logic [INST_W-1:0]   skid_inst_nxt_s;
    logic [DW-1:0]       skid_data_r;
    logic [DW-1:0]       skid_data_nxt_s;
    logic                up_ready_r;
    logic                dn_valid_r;
    logic                up_fire_s;
    logic                dn_fire_s;

    assign up_fire_s  = up_valid_i & up_ready_r;
    assign dn_fire_s  = dn_valid_r & dn_ready_i;

    assign up_ready_o = up_ready_r;
    assign dn_valid_o = dn_valid_r;
    assign dn_inst_o  = main_inst_r;
    assign dn_data_o  = main_data_r;

    // Next-state and storage decode; flush overrides every normal transition.
    always_comb begin
        state_nxt_s     = state_r;
        main_inst_nxt_s = main_inst_r;
        main_data_nxt_s = main_data_r;
        skid_inst_nxt_s = skid_inst_r;
        skid_data_nxt_s = skid_data_r;
        if (flush_i) begin
            state_nxt_s     = ST_EMPTY;
            main_inst_nxt_s = NOP_INST;
            main_data_nxt_s = {DW{1'b0}};
            skid_inst_nxt_s = NOP_INST;
            skid_data_nxt_s = {DW{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (up_fire_s) begin
                        state_nxt_s     = ST_BUSY;
                        main_inst_nxt_s = up_inst_i;
                        main_data_nxt_s = up_data_i;
                    end else begin
                        state_nxt_s     = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (up_fire_s && dn_fire_s) begin
                        state_nxt_s     = ST_BUSY;
                        main_inst_nxt_s = up_inst_i;
                        main_data_nxt_s = up_data_i;
                    end else if (up_fire_s) begin
                        state_nxt_s     = ST_FULL;
                        skid_inst_nxt_s = up_inst_i;
                        skid_data_nxt_s = up_data_i;
                    end else if (dn_fire_s) begin
                        // Emptying restores the bubble value on the outputs.
                        state_nxt_s     = ST_EMPTY;
                        main_inst_nxt_s = NOP_INST;
                        main_data_nxt_s = {DW{1'b0}};
                    end else begin
                        state_nxt_s     = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (dn_fire_s) begin
                        state_nxt_s     = ST_BUSY;
                        main_inst_nxt_s = skid_inst_r;
                        main_data_nxt_s = skid_data_r;
                        skid_inst_nxt_s = NOP_INST;
                        skid_data_nxt_s = {DW{1'b0}};
                    end else begin
                        state_nxt_s     = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s     = ST_EMPTY;
                    main_inst_nxt_s = NOP_INST;
                    main_data_nxt_s = {DW{1'b0}};
                    skid_inst_nxt_s = NOP_INST;
                    skid_data_nxt_s = {DW{1'b0}};
                end
            endcase
        end
    end

    // State, storage and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_inst_r <= NOP_INST;
            main_data_r <= {DW{1'b0}};
            skid_inst_r <= NOP_INST;
            skid_data_r <= {DW{1'b0}};
            up_ready_r  <= 1'b1;
            dn_valid_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            main_inst_r <= main_inst_nxt_s;
            main_data_r <= main_data_nxt_s;
            skid_inst_r <= skid_inst_nxt_s;
            skid_data_r <= skid_data_nxt_s;
            up_ready_r  <= (state_nxt_s != ST_FULL);
            dn_valid_r  <= (state_nxt_s != ST_EMPTY);
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;

    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (dn_valid_r && !dn_ready_i) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (flush_i && (state_r != ST_EMPTY)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_skid;
    localparam int DW = 96;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush_i = 1'b0;
    logic              up_valid_i = 1'b0;
    logic              up_ready_o;
    logic [INST_W-1:0] up_inst_i = '0;
    logic [DW-1:0]     up_data_i = '0;
    logic              dn_valid_o;
    logic              dn_ready_i = 1'b0;
    logic [INST_W-1:0] dn_inst_o;
    logic [DW-1:0]     dn_data_o;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt_o;
    logic [31:0]       flush_cnt_o;
`endif

    pipe_stage_skid #(.DW(DW), .INST_W(INST_W), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
        .up_inst_i(up_inst_i), .up_data_i(up_data_i),
        .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i),
        .dn_inst_o(dn_inst_o), .dn_data_o(dn_data_o)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference model: a FIFO of at most two entries.
    logic [INST_W+DW-1:0] q[$];
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    function automatic logic m_valid();
        return q.size() > 0;
    endfunction
    function automatic logic m_ready();
        return q.size() < 2;
    endfunction

    always @(posedge clk) begin
        logic upf, dnf;
        upf = up_valid_i & m_ready();
        dnf = m_valid() & dn_ready_i;
        if (rst) begin
            q.delete();
            m_stall = 32'd0;
            m_flush = 32'd0;
        end else begin
            if (m_valid() && !dn_ready_i) m_stall = m_stall + 32'd1;
            if (flush_i && q.size() > 0) m_flush = m_flush + 32'd1;
            if (flush_i) begin
                q.delete();
            end else begin
                if (dnf) void'(q.pop_front());
                if (upf) q.push_back({up_inst_i, up_data_i});
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dn_valid", {127'd0, dn_valid_o}, {127'd0, m_valid()});
            check("model_up_ready", {127'd0, up_ready_o}, {127'd0, m_ready()});
            check("model_dn_inst", {96'd0, dn_inst_o},
                  {96'd0, (q.size() > 0) ? q[0][INST_W+DW-1:DW] : NOP});
            check("model_dn_data", {32'd0, dn_data_o},
                  {32'd0, (q.size() > 0) ? q[0][DW-1:0] : {DW{1'b0}}});
`ifdef PIPE_STAGE_PERF_EN
            check("model_stall_cnt", {96'd0, stall_cnt_o}, {96'd0, m_stall});
            check("model_flush_cnt", {96'd0, flush_cnt_o}, {96'd0, m_flush});
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic v, input logic [31:0] inst);
        up_valid_i = v;
        up_inst_i  = inst;
        up_data_i  = {inst, ~inst, inst ^ 32'hA5A5A5A5};
    endtask

    task automatic pin(input string name, input logic v, input logic r, input logic [31:0] inst);
        check({name, "_valid"}, {127'd0, dn_valid_o}, {127'd0, v});
        check({name, "_ready"}, {127'd0, up_ready_o}, {127'd0, r});
        check({name, "_inst"}, {96'd0, dn_inst_o}, {96'd0, inst});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle.
        rst = 1'b1;
        cyc(); cyc();
        chk_en = 1'b1;
        rst = 1'b0;
        pin("reset", 1'b0, 1'b1, 32'h00000013);
        check("reset_data", {32'd0, dn_data_o}, 128'd0);
        cyc();
        pin("idle", 1'b0, 1'b1, 32'h00000013);

        // Streaming at full rate.
        dn_ready_i = 1'b1;
        offer(1'b1, 32'h00100093); cyc(); pin("stream1", 1'b1, 1'b1, 32'h00100093);
        check("stream1_data", {32'd0, dn_data_o},
              {32'd0, 32'h00100093, 32'hFFEFFF6C, 32'hA5B5A536});
        offer(1'b1, 32'h00200113); cyc(); pin("stream2", 1'b1, 1'b1, 32'h00200113);
        offer(1'b1, 32'h00300193); cyc(); pin("stream3", 1'b1, 1'b1, 32'h00300193);
        offer(1'b0, 32'h0); cyc(); pin("stream_end", 1'b0, 1'b1, 32'h00000013);

        // Stall fill then drain.
        dn_ready_i = 1'b0;
        offer(1'b1, 32'h11); cyc(); pin("fill_a", 1'b1, 1'b1, 32'h11);
        offer(1'b1, 32'h22); cyc(); pin("fill_b", 1'b1, 1'b0, 32'h11);
        offer(1'b0, 32'h0);  cyc(); pin("fill_hold", 1'b1, 1'b0, 32'h11);
        dn_ready_i = 1'b1;   cyc(); pin("drain_b", 1'b1, 1'b1, 32'h22);
        cyc(); pin("drain_end", 1'b0, 1'b1, 32'h00000013);

        // Flush while full, with a concurrent upstream offer.
        dn_ready_i = 1'b0;
        offer(1'b1, 32'h11); cyc();
        offer(1'b1, 32'h22); cyc();
        flush_i = 1'b1;
        offer(1'b1, 32'h33); cyc();
        pin("flush_full", 1'b0, 1'b1, 32'h00000013);
        flush_i = 1'b0;
        offer(1'b0, 32'h0);
        dn_ready_i = 1'b1; cyc(); cyc();
        pin("post_flush", 1'b0, 1'b1, 32'h00000013);

        // Reset mid-operation beats flush and downstream fire.
        dn_ready_i = 1'b0;
        offer(1'b1, 32'h11); cyc();
        offer(1'b1, 32'h22); cyc();
        offer(1'b0, 32'h0);
        rst = 1'b1; flush_i = 1'b1; dn_ready_i = 1'b1; cyc();
        pin("mid_reset", 1'b0, 1'b1, 32'h00000013);
        rst = 1'b0; flush_i = 1'b0;
        offer(1'b1, 32'h44); cyc(); pin("after_reset_d", 1'b1, 1'b1, 32'h44);
        offer(1'b0, 32'h0); cyc();

        // Mixed valid/ready traffic checked by the model.
        for (int i = 0; i < 60; i++) begin
            offer($urandom_range(0, 1) == 1, 32'h1000 + i);
            dn_ready_i = ($urandom_range(0, 2) != 0);
            flush_i = (i == 37);
            cyc();
        end
        flush_i = 1'b0;
        offer(1'b0, 32'h0);
        dn_ready_i = 1'b1; cyc(); cyc();

`ifdef PIPE_STAGE_PERF_EN
        rst = 1'b1; cyc(); rst = 1'b0;
        dn_ready_i = 1'b0;
        offer(1'b1, 32'h55); cyc();
        offer(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) cyc();
        flush_i = 1'b1; dn_ready_i = 1'b1; cyc();
        check("perf_stall5", {96'd0, stall_cnt_o}, 128'd5);
        check("perf_flush1", {96'd0, flush_cnt_o}, 128'd1);
        cyc();
        flush_i = 1'b0;
        check("perf_flush_empty", {96'd0, flush_cnt_o}, 128'd1);
`endif

        cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
